// File: rtl/scan_select_sequencer.sv
// scan_select_sequencer: timed 3-bit code generator that drives the A/B/C
// select inputs of a 3-to-8 one-hot decoder. Each code is held for
// dwell+1 enabled cycles, the scan runs up or down, and the code can be
// frozen or loaded. step/wrap are one-cycle pulses aligned with the first
// cycle a new code is visible.
//
// Edge priority: reset > load > enabled advance/count > hold.
// All outputs come straight from flops, so the decoder sees exactly one
// clean code change per advance.
module scan_select_sequencer #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               dir,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               load,
   input  logic [2:0]         load_val,
   output logic               A,
   output logic               B,
   output logic               C,
   output logic               step,
   output logic               wrap
);

   logic [2:0]         code_q,  code_d;
   logic [DWELL_W-1:0] timer_q, timer_d;
   logic               step_q,  step_d;
   logic               wrap_q,  wrap_d;

   // Next-state: load wins over run; the >= compare against the live dwell
   // means a shrinking dwell advances on the next enabled edge and the
   // timer never has to wrap through 2^DWELL_W.
   always_comb begin
      code_d  = code_q;
      timer_d = timer_q;
      step_d  = 1'b0;
      wrap_d  = 1'b0;
      if (load) begin
         code_d  = load_val;
         timer_d = '0;
      end else if (en) begin
         if (timer_q >= dwell) begin
            timer_d = '0;
            step_d  = 1'b1;
            if (dir) begin
               code_d = code_q - 3'd1;
               wrap_d = (code_q == 3'd0);
            end else begin
               code_d = code_q + 3'd1;
               wrap_d = (code_q == 3'd7);
            end
         end else begin
            timer_d = timer_q + DWELL_W'(1);
         end
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         code_q  <= 3'd0;
         timer_q <= '0;
         step_q  <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         code_q  <= code_d;
         timer_q <= timer_d;
         step_q  <= step_d;
         wrap_q  <= wrap_d;
      end
   end

   assign A    = code_q[2];
   assign B    = code_q[1];
   assign C    = code_q[0];
   assign step = step_q;
   assign wrap = wrap_q;

endmodule
